// File: rtl/accu_pkg.sv
// accu_pkg: opcode and operand-source enums shared by the accumulator slice
package accu_pkg;
  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LOAD = 4'd1,
    OP_PUSH = 4'd2,
    OP_POP  = 4'd3,
    OP_SWAP = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_NOT  = 4'd8,
    OP_ADD  = 4'd9,
    OP_SUB  = 4'd10,
    OP_CLR  = 4'd11
  } accu_op_e;
  typedef enum logic [1:0] {
    SRC_ARG = 2'd0,
    SRC_IO  = 2'd1,
    SRC_REG = 2'd2,
    SRC_RAM = 2'd3
  } accu_src_e;
endpackage

// File: rtl/accu_lifo.sv
// accu_lifo: shift-register LIFO (push/pop/replace-top in, top/depth/full/empty out); entries at or above depth are kept zero so top reads 0 when empty
module accu_lifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             CPU_Reset,
  input  logic             push,
  input  logic             pop,
  input  logic             replace,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    depth,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge CLK or posedge CPU_Reset)
    if (CPU_Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      depth <= '0;
    end else if (push) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
      depth <= depth + 1'b1;
    end else if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      mem[DEPTH-1] <= '0;
      depth <= depth - 1'b1;
    end else if (replace)
      mem[0] <= din;
  assign top   = mem[0];
  assign full  = depth == CW'(DEPTH);
  assign empty = depth == '0;
endmodule

// File: rtl/accu_stack.sv
// accu_stack: ACCU1 + LIFO PLC accumulator (CLK, CPU_Reset, ACCU_WE/OPCode/SrcSel/operands/ErrClr in; ACCUMULATOR, ACCU2, ACCU_Depth, Zero/Carry/StackErr out); ACCU_ARITH_EN enables ADD/SUB
module accu_stack
  import accu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             CPU_Reset,
  input  logic             ACCU_WE,
  input  logic [3:0]       ACCU_OPCode,
  input  logic [1:0]       ACCU_SrcSel,
  input  logic [WIDTH-1:0] ACCU_ArgToSet,
  input  logic [WIDTH-1:0] ACCU_AnyDataInput,
  input  logic [WIDTH-1:0] ACCU_Register,
  input  logic [WIDTH-1:0] ACCU_RAMData,
  input  logic             ACCU_ErrClr,
  output logic [WIDTH-1:0] ACCUMULATOR,
  output logic [WIDTH-1:0] ACCU2,
  output logic [CW-1:0]    ACCU_Depth,
  output logic             ACCU_Zero,
  output logic             ACCU_Carry,
  output logic             ACCU_StackErr
);
  logic [WIDTH-1:0] acc, acc_n, src, top;
  logic full, empty, is_push, is_pop, is_swap, err, stack_err;
  assign src = ACCU_SrcSel == SRC_ARG ? ACCU_ArgToSet :
               ACCU_SrcSel == SRC_IO  ? ACCU_AnyDataInput :
               ACCU_SrcSel == SRC_REG ? ACCU_Register : ACCU_RAMData;
  assign is_push = ACCU_WE && ACCU_OPCode == OP_PUSH;
  assign is_pop  = ACCU_WE && ACCU_OPCode == OP_POP;
  assign is_swap = ACCU_WE && ACCU_OPCode == OP_SWAP;
  assign err     = (is_push && full) || ((is_pop || is_swap) && empty);
  accu_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lifo (
    .CLK       (CLK),
    .CPU_Reset (CPU_Reset),
    .push      (is_push && !full),
    .pop       (is_pop && !empty),
    .replace   (is_swap && !empty),
    .din       (acc),
    .top       (top),
    .depth     (ACCU_Depth),
    .full      (full),
    .empty     (empty)
  );
`ifdef ACCU_ARITH_EN
  logic [WIDTH:0] sum;
  logic carry;
  assign sum = ACCU_OPCode == OP_SUB ? {1'b0, acc} - {1'b0, src} : {1'b0, acc} + {1'b0, src};
  always_ff @(posedge CLK or posedge CPU_Reset)
    if (CPU_Reset) carry <= 1'b0;
    else if (ACCU_WE && (ACCU_OPCode == OP_ADD || ACCU_OPCode == OP_SUB)) carry <= sum[WIDTH];
  assign ACCU_Carry = carry;
`else
  assign ACCU_Carry = 1'b0;
`endif
  always_comb begin
    acc_n = acc;
    if (ACCU_WE && !err)
      case (ACCU_OPCode)
        OP_LOAD, OP_PUSH: acc_n = src;
        OP_POP, OP_SWAP:  acc_n = top;
        OP_AND:           acc_n = acc & src;
        OP_OR:            acc_n = acc | src;
        OP_XOR:           acc_n = acc ^ src;
        OP_NOT:           acc_n = ~acc;
`ifdef ACCU_ARITH_EN
        OP_ADD, OP_SUB:   acc_n = sum[WIDTH-1:0];
`endif
        OP_CLR:           acc_n = '0;
        default:          acc_n = acc;
      endcase
  end
  always_ff @(posedge CLK or posedge CPU_Reset)
    if (CPU_Reset) begin
      acc       <= '0;
      stack_err <= 1'b0;
    end else begin
      acc       <= acc_n;
      stack_err <= err ? 1'b1 : ACCU_ErrClr ? 1'b0 : stack_err;
    end
  assign ACCUMULATOR   = acc;
  assign ACCU2         = top;
  assign ACCU_Zero     = acc == '0;
  assign ACCU_StackErr = stack_err;
endmodule
